// File: rtl/mem_master_pkg.sv
// mem_master_pkg: shared state encoding, response status codes and stats width for mem_master.
package mem_master_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;
  localparam logic [1:0] STS_OK      = 2'b00;
  localparam logic [1:0] STS_RANGE   = 2'b01;
  localparam logic [1:0] STS_TIMEOUT = 2'b10;
  localparam int STAT_W = 16;
endpackage

// File: rtl/mem_master_timer.sv
// mem_master_timer: access watchdog; expire is high on the TIMEOUT-th enabled cycle after clear.
module mem_master_timer #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : (en ? cnt_q + 1'b1 : cnt_q);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire = en && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_master.sv
// mem_master: one-at-a-time command engine driving the wr/rd memory bus with range check and timeout.
// Optional MEM_MASTER_STATS_EN adds saturating wr/rd/err completion counters.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16,
  parameter int TIMEOUT    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_status,
  output logic                  wr,
  output logic                  rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
`ifdef MEM_MASTER_STATS_EN
  output logic [STAT_W-1:0]     wr_count,
  output logic [STAT_W-1:0]     rd_count,
  output logic [STAT_W-1:0]     err_count,
`endif
  input  logic                  response
);
  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_status_q, rsp_status_d;
  logic                  expire, cmd_hs, rsp_hs, in_range, in_access;
  assign cmd_hs    = cmd_valid && cmd_ready_q;
  assign rsp_hs    = rsp_valid_q && rsp_ready;
  assign in_range  = 64'(cmd_addr) < 64'(MEM_SIZE);
  assign in_access = state_q == ST_ACCESS;
  mem_master_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_access),
    .en     (in_access),
    .expire (expire)
  );
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    unique case (state_q)
      ST_IDLE:
        if (cmd_hs && in_range) begin
          state_d = ST_ACCESS;
          wr_d    = cmd_wr;
          rd_d    = !cmd_wr;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
        end else if (cmd_hs) begin
          state_d      = ST_DONE;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = '0;
          rsp_status_d = STS_RANGE;
        end
      ST_ACCESS:
        // a response arriving on the expiry cycle still counts as success
        if (response || expire) begin
          state_d      = ST_DONE;
          wr_d         = 1'b0;
          rd_d         = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = (response && rd_q) ? rdata : '0;
          rsp_status_d = response ? STS_OK : STS_TIMEOUT;
        end
      ST_DONE:
        if (rsp_hs) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = state_d == ST_IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= STS_OK;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  assign cmd_ready  = cmd_ready_q;
  assign wr         = wr_q;
  assign rd         = rd_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_status = rsp_status_q;
`ifdef MEM_MASTER_STATS_EN
  logic [STAT_W-1:0] wr_count_q, wr_count_d, rd_count_q, rd_count_d, err_count_q, err_count_d;
  logic              ok_wr, ok_rd, err;
  assign ok_wr = in_access && response && wr_q;
  assign ok_rd = in_access && response && rd_q;
  assign err   = (in_access && !response && expire) || (state_q == ST_IDLE && cmd_hs && !in_range);
  always_comb begin
    wr_count_d  = wr_count_q + STAT_W'(ok_wr && wr_count_q != '1);
    rd_count_d  = rd_count_q + STAT_W'(ok_rd && rd_count_q != '1);
    err_count_d = err_count_q + STAT_W'(err && err_count_q != '1);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_count_q  <= '0;
      rd_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      err_count_q <= err_count_d;
    end
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;
  assign err_count = err_count_q;
`endif
endmodule
